// File: rtl/ysyx_24100027_pkg.sv
// ysyx_24100027_pkg: shared states, halt codes and instruction constants for the core sequencer
package ysyx_24100027_pkg;
  localparam int XLEN = 32;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_NOP = 32'h0000_0013;
  localparam logic [2:0] HALT_NONE = 3'd0;
  localparam logic [2:0] HALT_EBREAK = 3'd1;
  localparam logic [2:0] HALT_BUSERR = 3'd2;
  localparam logic [2:0] HALT_TIMEOUT = 3'd3;
  localparam logic [2:0] HALT_MISALIGN = 3'd4;
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_EXEC, S_HALT} state_t;
endpackage

// File: rtl/ysyx_24100027_timeout_cnt.sv
// ysyx_24100027_timeout_cnt: clear/enable counter flagging terminal count TIMEOUT-1 (TIMEOUT=0 disables)
module ysyx_24100027_timeout_cnt #(
  parameter logic [15:0] TIMEOUT = 16'd1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);
  logic [15:0] cnt;
  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (en) cnt <= cnt + 16'd1;
  end
  assign tc = (TIMEOUT != 16'd0) && (cnt == TIMEOUT - 16'd1);
endmodule

// File: rtl/ysyx_24100027_core_seq.sv
// ysyx_24100027_core_seq: multi-cycle fetch/exec sequencer owning pc, inst, write-back gating and sticky halts
module ysyx_24100027_core_seq
  import ysyx_24100027_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [15:0] TIMEOUT = 16'd1024
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  output logic            ifu_req_valid,
  input  logic            ifu_req_ready,
  output logic [XLEN-1:0] ifu_req_addr,
  input  logic            ifu_rsp_valid,
  input  logic [XLEN-1:0] ifu_rsp_data,
  input  logic            ifu_rsp_err,
  output logic [XLEN-1:0] cpu_pc,
  output logic [XLEN-1:0] cpu_inst,
  input  logic [XLEN-1:0] cpu_npc,
  output logic            cpu_wb_en,
  output logic            halt,
  output logic [2:0]      halt_code,
  output logic [XLEN-1:0] retire_cnt
);
  state_t state, state_n;
  logic [XLEN-1:0] pc, inst, retire;
  logic [2:0] code;
  logic to_tc, is_ebreak, misal;
  ysyx_24100027_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_to (
    .clk(clk),
    .rst(rst),
    .clr(state == S_REQ),
    .en(state == S_WAIT),
    .tc(to_tc)
  );
  assign is_ebreak = inst == INST_EBREAK;
  assign misal = cpu_npc[1:0] != 2'b00;
  always_comb begin
    state_n = state;
    ifu_req_valid = state == S_REQ;
    cpu_wb_en = (state == S_EXEC) && !is_ebreak && !misal;
    halt = state == S_HALT;
    case (state)
      S_IDLE: state_n = run ? S_REQ : S_IDLE;
      S_REQ: state_n = ifu_req_ready ? S_WAIT : S_REQ;
      S_WAIT: state_n = ifu_rsp_valid ? (ifu_rsp_err ? S_HALT : S_EXEC) : (to_tc ? S_HALT : S_WAIT);
      S_EXEC: state_n = (is_ebreak || misal) ? S_HALT : (run ? S_REQ : S_IDLE);
      default: state_n = S_HALT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      pc <= RESET_PC;
      inst <= INST_NOP;
      code <= HALT_NONE;
      retire <= '0;
    end else begin
      state <= state_n;
      if (state == S_WAIT && ifu_rsp_valid && !ifu_rsp_err) inst <= ifu_rsp_data;
      if (cpu_wb_en) pc <= cpu_npc;
      if (state == S_EXEC && (is_ebreak || !misal)) retire <= retire + 32'd1;
      if (state != S_HALT && state_n == S_HALT)
        code <= (state == S_WAIT) ? (ifu_rsp_valid ? HALT_BUSERR : HALT_TIMEOUT) : (is_ebreak ? HALT_EBREAK : HALT_MISALIGN);
    end
  end
  assign ifu_req_addr = pc;
  assign cpu_pc = pc;
  assign cpu_inst = inst;
  assign halt_code = code;
  assign retire_cnt = retire;
endmodule
